// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    function automatic int baud_cnt_max(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty come from the extra pointer MSB.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: clearing the pointers already discards its contents.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 transmitter: byte FIFO in front of a baud-timed shift FSM.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       pi_data,
    input  logic             pi_flag,
    output logic             pi_ready,
    output logic             tx,
    output logic             tx_busy,
    output logic             flag_txe,
    output logic [CNT_W-1:0] fifo_cnt,
    output logic             ovf_flag,
    output state_t           dbg_state
);
    // Handshake: a byte is taken on any rising edge where pi_flag=1 and
    // pi_ready=1; pi_flag=1 with pi_ready=0 drops the byte and pulses ovf_flag.
    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD_RATE);
    localparam int BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int FCW          = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W        = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    ovf_flag_q, ovf_flag_d;

    logic                    pop;
    logic                    bit_end;
    logic [7:0]              fifo_head;
    logic                    fifo_full, fifo_empty;
    logic [FCW-1:0]          fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (pi_flag),
        .wr_data (pi_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        bit_end    = (baud_cnt_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_head;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_head;
                        bit_cnt_d = '0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state one cycle later, so each bit keeps its full width.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        busy_d     = (state_q != IDLE);
        ovf_flag_d = pi_flag && fifo_full;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    assign tx        = tx_q;
    assign tx_busy   = busy_q;
    assign ovf_flag  = ovf_flag_q;
    assign pi_ready  = !fifo_full;
    assign fifo_cnt  = CNT_W'(fifo_count);
    // Stays low through the last stop bit, which is still on the line after the FSM returns to IDLE.
    assign flag_txe  = fifo_empty && (state_q == IDLE) && !busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: reference model, serial decoder, directed and random traffic.
`timescale 1ns/1ps
module tb_uart_tx_buffered;
    localparam int M      = 16;           // 160 Hz / 10 baud
    localparam int FRAME  = 10 * M;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;
    localparam int M2     = 434;          // 50 MHz / 115200 baud

    // ---------------- clock / reset ----------------
    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic [7:0]       pi_data = 8'h00;
    logic             pi_flag = 1'b0;
    logic             pi_ready, tx, tx_busy, flag_txe, ovf_flag;
    logic [CNT_W-1:0] fifo_cnt;
    logic [1:0]       dbg_state;

    logic [7:0]       pi_data2 = 8'h00;
    logic             pi_flag2 = 1'b0;
    logic             pi_ready2, tx2, tx_busy2, flag_txe2, ovf_flag2;
    logic [CNT_W-1:0] fifo_cnt2;
    logic [1:0]       dbg_state2;

    always #5 sys_clk = ~sys_clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    uart_tx_buffered #(
        .CLK_FREQ(160), .BAUD_RATE(10), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
        .pi_ready(pi_ready), .tx(tx), .tx_busy(tx_busy), .flag_txe(flag_txe),
        .fifo_cnt(fifo_cnt), .ovf_flag(ovf_flag), .dbg_state(dbg_state)
    );

    uart_tx_buffered #(
        .CLK_FREQ(50_000_000), .BAUD_RATE(115200), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data2), .pi_flag(pi_flag2),
        .pi_ready(pi_ready2), .tx(tx2), .tx_busy(tx_busy2), .flag_txe(flag_txe2),
        .fifo_cnt(fifo_cnt2), .ovf_flag(ovf_flag2), .dbg_state(dbg_state2)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A queue of waiting bytes plus the age of the frame on the line; the line
    // shows bit (age / M) of {stop, data, start} one cycle after each edge.
    logic [7:0] model_q[$];
    int         el = FRAME;
    logic [9:0] fb = 10'h3ff;
    logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_txe = 1'b1, exp_ready = 1'b1, exp_ovf = 1'b0;
    int         exp_cnt = 0;

    always @(posedge sys_clk) begin : model
        int         pre;
        logic       was_busy, is_full;
        logic [7:0] head;
        if (sys_rst) begin
            model_q.delete();
            exp_q.delete();
            el = FRAME; fb = 10'h3ff;
            exp_tx = 1'b1; exp_busy = 1'b0; exp_txe = 1'b1; exp_ready = 1'b1; exp_ovf = 1'b0; exp_cnt = 0;
        end else begin
            was_busy = (el < FRAME);
            pre      = model_q.size();
            is_full  = (pre == DEPTH);
            exp_tx   = was_busy ? fb[el / M] : 1'b1;
            exp_busy = was_busy;
            if (el >= FRAME - 1 && pre > 0) begin
                head = model_q.pop_front();
                fb   = {1'b1, head, 1'b0};
                el   = 0;
            end else if (el < FRAME) begin
                el++;
            end
            exp_ovf = pi_flag && is_full;
            if (pi_flag && !is_full) begin
                model_q.push_back(pi_data);
                exp_q.push_back(pi_data);
            end
            exp_cnt   = model_q.size();
            exp_ready = (model_q.size() < DEPTH);
            exp_txe   = (model_q.size() == 0) && (el >= FRAME) && !exp_busy;
        end
    end

    always @(negedge sys_clk) begin : cycle_check
        check("tx", tx, exp_tx);
        check("tx_busy", tx_busy, exp_busy);
        check("flag_txe", flag_txe, exp_txe);
        check("fifo_cnt", fifo_cnt, exp_cnt);
        check("pi_ready", pi_ready, exp_ready);
        check("ovf_flag", ovf_flag, exp_ovf);
    end

    // ---------------- serial decoder (monitor) ----------------
    logic       dec_on = 1'b0;
    int         dec_pos = 0;
    int         dec_frames = 0;
    logic [9:0] dec_bits;

    always @(negedge sys_clk) begin : decoder
        logic [7:0] want;
        if (sys_rst) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (tx === 1'b0) begin
                dec_on  = 1'b1;
                dec_pos = 0;
            end
        end else begin
            dec_pos++;
            if (dec_pos % M == M / 2) dec_bits[dec_pos / M] = tx;
            if (dec_pos == 9 * M + M / 2) begin
                dec_on = 1'b0;
                dec_frames++;
                check("dec_start_bit", dec_bits[0], 1'b0);
                check("dec_stop_bit", dec_bits[9], 1'b1);
                check("dec_queue_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    check("dec_byte", dec_bits[8:1], want);
                end
            end
        end
    end

    // ---------------- event counters ----------------
    int   busy_cycles = 0, busy_drops = 0, ovf_pulses = 0, cnt_peak = 0, busy2_cycles = 0;
    logic prev_busy = 1'b0;

    always @(negedge sys_clk) begin : counters
        if (tx_busy === 1'b1) busy_cycles++;
        if (prev_busy && tx_busy === 1'b0) busy_drops++;
        prev_busy = (tx_busy === 1'b1);
        if (ovf_flag === 1'b1) ovf_pulses++;
        if (int'(fifo_cnt) > cnt_peak) cnt_peak = int'(fifo_cnt);
        if (tx_busy2 === 1'b1) busy2_cycles++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic f, input logic [7:0] d);
        pi_flag = f;
        pi_data = d;
        @(negedge sys_clk);
        pi_flag = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (flag_txe !== 1'b1 && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        check("idle_within_bound", flag_txe, 1'b1);
        @(negedge sys_clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int n, len, frames0;
        logic lvl;

        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        check("rst_tx", tx, 1'b1);
        check("rst_flag_txe", flag_txe, 1'b1);
        check("rst_pi_ready", pi_ready, 1'b1);
        check("rst_fifo_cnt", fifo_cnt, 0);
        check("rst_state", dbg_state, 0);
        repeat (2) @(negedge sys_clk);

        // Single byte: latency and frame length.
        busy_cycles = 0;
        frames0 = dec_frames;
        drive(1'b1, 8'haa);
        check("t1_txe_low_after_write", flag_txe, 1'b0);
        check("t1_tx_at_k", tx, 1'b1);
        @(negedge sys_clk);
        check("t1_tx_at_k1", tx, 1'b1);
        @(negedge sys_clk);
        check("t1_tx_at_k2", tx, 1'b0);
        wait_idle(2 * FRAME);
        check("t1_busy_len", busy_cycles, FRAME);
        check("t1_frames", dec_frames - frames0, 1);

        // Back-to-back burst of four.
        busy_cycles = 0; busy_drops = 0; cnt_peak = 0;
        frames0 = dec_frames;
        drive(1'b1, 8'haa);
        drive(1'b1, 8'haf);
        drive(1'b1, 8'h0a);
        drive(1'b1, 8'h0e);
        wait_idle(6 * FRAME);
        check("t2_cnt_peak", cnt_peak, 3);
        check("t2_busy_len", busy_cycles, 4 * FRAME);
        check("t2_no_gap", busy_drops, 1);
        check("t2_frames", dec_frames - frames0, 4);

        // Fill to full while a frame is shifting; two writes overflow.
        drive(1'b1, 8'($urandom));
        @(negedge sys_clk);
        #1;
        ovf_pulses = 0;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 8'($urandom));
            if (i == 14) check("t3_ready_at_15", pi_ready, 1'b1);
            if (i == 15) begin
                check("t3_cnt_full", fifo_cnt, 16);
                check("t3_ready_low", pi_ready, 1'b0);
            end
        end
        @(negedge sys_clk);
        #1;
        check("t3_ovf_pulses", ovf_pulses, 2);
        wait_idle(20 * FRAME);

        // Write on the same edge as a stop-to-start pop with five queued.
        drive(1'b1, 8'($urandom));
        @(negedge sys_clk);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom));
        check("t4_cnt_before", fifo_cnt, 5);
        n = 0;
        while (el != FRAME - 1 && n < 2 * FRAME) begin
            @(negedge sys_clk);
            n++;
        end
        check("t4_reached_pop_edge", el, FRAME - 1);
        drive(1'b1, 8'($urandom));
        check("t4_cnt_after", fifo_cnt, 5);
        check("t4_busy_kept", tx_busy, 1'b1);
        wait_idle(10 * FRAME);

        // Asynchronous reset mid data bit 3 with two bytes queued.
        drive(1'b1, 8'h0e);
        @(negedge sys_clk);
        drive(1'b1, 8'($urandom));
        drive(1'b1, 8'($urandom));
        n = 0;
        while (el != 4 * M + M / 2 && n < 2 * FRAME) begin
            @(negedge sys_clk);
            n++;
        end
        check("t5_reached_bit3", el, 4 * M + M / 2);
        check("t5_cnt_queued", fifo_cnt, 2);
        #2;
        sys_rst = 1'b1;
        #1;
        check("t5_rst_tx", tx, 1'b1);
        check("t5_rst_busy", tx_busy, 1'b0);
        check("t5_rst_cnt", fifo_cnt, 0);
        check("t5_rst_txe", flag_txe, 1'b1);
        check("t5_rst_ready", pi_ready, 1'b1);
        check("t5_rst_state", dbg_state, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        #1;
        busy_cycles = 0;
        frames0 = dec_frames;
        repeat (3 * FRAME) @(negedge sys_clk);
        #1;
        check("t5_no_frame_busy", busy_cycles, 0);
        check("t5_no_frame_dec", dec_frames - frames0, 0);

        // Random traffic, including overflow bursts.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, 8'($urandom));
        end
        wait_idle(20 * FRAME);

        // Faster line rate on the second instance: 0x55 alternates every bit.
        busy2_cycles = 0;
        pi_data2 = 8'h55;
        pi_flag2 = 1'b1;
        @(negedge sys_clk);
        pi_flag2 = 1'b0;
        n = 0;
        while (tx2 !== 1'b0 && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        check("t6_latency", n, 2);
        for (int r = 0; r < 9; r++) begin
            lvl = r[0];
            len = 0;
            while (tx2 === lvl && len < 2 * M2) begin
                len++;
                @(negedge sys_clk);
            end
            check("t6_bit_len", len, M2);
        end
        len = 0;
        while (tx2 === 1'b1 && tx_busy2 === 1'b1 && len < 2 * M2) begin
            len++;
            @(negedge sys_clk);
        end
        check("t6_stop_len", len, M2);
        #1;
        check("t6_busy_len", busy2_cycles, 10 * M2);
        check("t6_txe", flag_txe2, 1'b1);
        check("t6_cnt", fifo_cnt2, 0);
        check("t6_ready", pi_ready2, 1'b1);
        check("t6_ovf", ovf_flag2, 1'b0);
        check("t6_state", dbg_state2, 0);

        check("final_exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered RS232 transmitter: accepts parallel bytes over a valid/ready strobe, queues them in an internal FIFO, and serialises each as an 8N1 frame (LSB first) on `tx`.
- It is the outbound half of the UART path and is driven from the receiver's `po_data`/`po_flag` side or from user logic.
- The FIFO absorbs back-to-back bytes so that received bursts are echoed without loss.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s. BAUD_CNT_MAX = CLK_FREQ/BAUD_RATE (integer division), which is 5208 at the defaults.
- FIFO_DEPTH, 16: byte capacity of the queue; must be a power of 2, minimum 2.
- CNT_W, 5: width of `fifo_cnt`, equal to log2(FIFO_DEPTH)+1.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- pi_data  in  8  byte to send.
- pi_flag  in  1  one-cycle write strobe; `pi_data` is valid while it is high.
- pi_ready  out  1  high when the FIFO is not full.
- tx  out  1  serial line; idles high.
- tx_busy  out  1  high while a frame is on the line (start through end of stop).
- flag_txe  out  1  high when the FIFO is empty AND the FSM is in IDLE.
- fifo_cnt  out  CNT_W  number of queued bytes, excluding the one being shifted.
- ovf_flag  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Clock and reset: single clock `sys_clk`. Reset `sys_rst` is asynchronous and active-high. Assertion at any time, including mid-frame, immediately forces:
  - tx=1, tx_busy=0, flag_txe=1, pi_ready=1, fifo_cnt=0, ovf_flag=0;
  - FIFO pointers cleared and queued data discarded;
  - FSM to IDLE.
- FIFO:
  - Show-ahead (first-word-fall-through); the head byte is readable combinationally.
  - Write occurs when pi_flag=1 and full=0.
  - pi_flag=1 while full is dropped and pulses ovf_flag on the next cycle. This applies even if a pop happens in the same cycle.
  - A simultaneous accepted write and pop leaves fifo_cnt unchanged.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are decided from the extra pointer MSB.
- Baud counter: counts 0..BAUD_CNT_MAX-1 within each bit and resets at every state entry. Each bit is held exactly BAUD_CNT_MAX cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is not empty: pop the head into the shift register, set bit_cnt=0, and go to START. tx goes low on the cycle after the pop edge.
  - START: tx=0 for BAUD_CNT_MAX cycles, then go to DATA.
  - DATA: tx=shift_reg[0]. At the end of each bit, shift right and increment bit_cnt. After bit_cnt=7 completes, go to STOP.
  - STOP: tx=1 for BAUD_CNT_MAX cycles. At the end:
    - if the FIFO is not empty, pop and go directly to START, so there is no idle gap between frames;
    - otherwise go to IDLE.
- Frame length is exactly 10×BAUD_CNT_MAX cycles.
- Latency: pi_flag sampled at edge k into an empty idle block gives:
  - FIFO write at k;
  - pop at k+1;
  - tx=0 from k+2.
- tx_busy is high in START, DATA and STOP. flag_txe is low from the write edge until the final stop bit of the last queued byte ends.
- `tx` is driven from a register, so it is glitch-free.

Decomposition:
- Package `uart_pkg`:
  - state enum {IDLE, START, DATA, STOP};
  - FRAME_BITS=10, DATA_BITS=8;
  - function baud_cnt_max(clk_freq, baud).
- Sub-module `sync_fifo`:
  - parameters WIDTH, DEPTH;
  - ports wr_en, wr_data, rd_en, rd_data, full, empty, count;
  - same reset.
- The FSM and baud counter stay in the top module.

Test Plan:
- Single byte 8'haa after reset release → tx low at k+2. Line sequence 0,0,1,0,1,0,1,0,1,1, each bit 5208 cycles. tx_busy high 52080 cycles. flag_txe returns high after the stop bit.
- Burst of 4 back-to-back bytes 8'haa, 8'haf, 8'h0a, 8'h0e on consecutive cycles → fifo_cnt peaks at 3. Four frames with no idle gap, 208320 cycles total. The bench's serial decoder reads exactly those bytes in order.
- 17 writes while a frame is shifting (fill to full) → pi_ready falls once fifo_cnt=16. Writes 17 onward pulse ovf_flag for one cycle each and are dropped. Exactly the first accepted bytes appear on the line.
- Write on the same cycle a pop occurs with fifo_cnt=5 → fifo_cnt stays 5. No data corrupted.
- sys_rst asserted mid DATA bit 3 of 8'h0e with 2 bytes queued → tx=1, tx_busy=0, fifo_cnt=0 with no clock edge needed. After release, no frame is sent until a new pi_flag.
- BAUD_RATE=115200 override (BAUD_CNT_MAX=434) with byte 8'h55 → each bit is 434 cycles and the frame is 4340 cycles.
